// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the memory port.
// The arbiter takes the slave view; requesters and memory drive the master view.
interface mem_bus_arbiter_if #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [SIZE-1:0]   if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [SIZE-1:0]   ls_wdata;
    logic              ls_gnt;
    logic              ls_valid;
    logic [SIZE-1:0]   ls_rdata;

    logic              bus_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [SIZE-1:0]   mem_wdata;
    logic [SIZE-1:0]   mem_rdata;
    logic              mem_ready;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  mem_rdata, mem_ready,
        output if_gnt, if_valid, if_rdata,
        output ls_gnt, ls_valid, ls_rdata,
        output bus_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output mem_rdata, mem_ready,
        input  if_gnt, if_valid, if_rdata,
        input  ls_gnt, ls_valid, ls_rdata,
        input  bus_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One access at a time, round-robin on contention, timeout abort.
module mem_bus_arbiter #(
    parameter int SIZE    = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              rstn,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic          owner_ls;
    logic          last_ls;
    logic [CW-1:0] cnt;
    logic          any_req;
    logic          pick_ls;

    assign any_req = bus.if_req | bus.ls_req;
    // on contention the side that did not own the last access wins
    assign pick_ls = bus.ls_req & (~bus.if_req | ~last_ls);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            owner_ls      <= 1'b0;
            last_ls       <= 1'b1;
            cnt           <= '0;
            bus.if_gnt    <= 1'b0;
            bus.if_valid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ls_gnt    <= 1'b0;
            bus.ls_valid  <= 1'b0;
            bus.ls_rdata  <= '0;
            bus.bus_err   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.if_valid <= 1'b0;
                    bus.ls_valid <= 1'b0;
                    bus.bus_err  <= 1'b0;
                    if (any_req) begin
                        state         <= BUSY;
                        owner_ls      <= pick_ls;
                        cnt           <= '0;
                        bus.if_gnt    <= ~pick_ls;
                        bus.ls_gnt    <= pick_ls;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= pick_ls & bus.ls_we;
                        bus.mem_addr  <= pick_ls ? bus.ls_addr : bus.if_addr;
                        bus.mem_wdata <= pick_ls ? bus.ls_wdata : '0;
                    end
                end
                BUSY: begin
                    bus.if_gnt <= 1'b0;
                    bus.ls_gnt <= 1'b0;
                    if (bus.mem_ready) begin
                        state      <= IDLE;
                        bus.mem_en <= 1'b0;
                        last_ls    <= owner_ls;
                        if (owner_ls) begin
                            bus.ls_valid <= 1'b1;
                            if (!bus.mem_we) bus.ls_rdata <= bus.mem_rdata;
                        end else begin
                            bus.if_valid <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end else if (cnt == LAST) begin
                        // memory never answered: release the bus with an error
                        state       <= IDLE;
                        bus.mem_en  <= 1'b0;
                        bus.bus_err <= 1'b1;
                        last_ls     <= owner_ls;
                        if (owner_ls) begin
                            bus.ls_valid <= 1'b1;
                            bus.ls_rdata <= '0;
                        end else begin
                            bus.if_valid <= 1'b1;
                            bus.if_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
